// File: rtl/regheap_pkg.sv
// Shared definitions for the register-heap accumulation sequencer.
//   LANES / LANE_W / DATA_W : heap geometry (64 lanes x 16b)
//   rh_state_t              : sequencer state encoding
package regheap_pkg;

    localparam int unsigned LANES  = 64;
    localparam int unsigned LANE_W = 16;
    localparam int unsigned DATA_W = LANES * LANE_W;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ACCUM,
        DRAIN,
        OUT
    } rh_state_t;

endpackage

// File: rtl/rh_beat_cnt.sv
// Beat counter with synchronous clear and terminal compare against a length.
//   clk, rst   : clock, asynchronous active-high reset
//   clr_i      : clear count to zero (wins over inc_i)
//   inc_i      : increment count by one
//   len_i      : terminal length
//   last_c_o   : combinational, high when count + 1 == len_i
module rh_beat_cnt #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic [CNT_W-1:0] len_i,
    output logic             last_c_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear has priority over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Compare one bit wider so a full count can never alias to zero.
    assign last_c_o = ({1'b0, cnt_q} + (CNT_W + 1)'(1)) == {1'b0, len_i};

endmodule

// File: rtl/regheap_accum_ctrl.sv
// Job sequencer for the 64x16b self-adding register heap.
// Takes a job length, clears the heap, forwards each accepted input vector
// as a one-cycle add strobe, counts returned heap valids and holds the final
// sum on a valid/ready result port.
//   clk, rst                     : clock, asynchronous active-high reset
//   start, cfg_len               : job request and length (sampled in IDLE)
//   busy, err_len0               : job in progress, zero-length request pulse
//   s_valid, s_ready, s_data     : input vector stream
//   heap_usr_rst                 : one-cycle heap clear
//   heap_data_v, heap_in_data    : heap add strobe and operand
//   heap_data_v_w, heap_data_w   : heap output valid and registers
//   m_valid, m_ready, m_data     : result handshake
//   done                         : one-cycle pulse on result handshake
module regheap_accum_ctrl #(
    parameter int unsigned DATA_W = regheap_pkg::DATA_W,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  cfg_len,
    output logic              busy,
    output logic              err_len0,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              heap_usr_rst,
    output logic              heap_data_v,
    output logic [DATA_W-1:0] heap_in_data,
    input  logic              heap_data_v_w,
    input  logic [DATA_W-1:0] heap_data_w,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              done
);

    import regheap_pkg::*;

    rh_state_t         state_q,    state_d;
    logic [CNT_W-1:0]  len_q,      len_d;
    logic              busy_q,     busy_d;
    logic              err_q,      err_d;
    logic              s_ready_q,  s_ready_d;
    logic              usr_rst_q,  usr_rst_d;
    logic              data_v_q,   data_v_d;
    logic [DATA_W-1:0] in_data_q,  in_data_d;
    logic              m_valid_q,  m_valid_d;
    logic [DATA_W-1:0] m_data_q,   m_data_d;
    logic              done_q,     done_d;

    logic sent_clr, sent_inc, sent_last;
    logic ret_clr,  ret_inc,  ret_last;

    rh_beat_cnt #(.CNT_W(CNT_W)) u_sent_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (sent_clr),
        .inc_i    (sent_inc),
        .len_i    (len_q),
        .last_c_o (sent_last)
    );

    rh_beat_cnt #(.CNT_W(CNT_W)) u_ret_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (ret_clr),
        .inc_i    (ret_inc),
        .len_i    (len_q),
        .last_c_o (ret_last)
    );

    // Next-state and next-output logic; every output register is loaded
    // with the value it must show in the following state.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        busy_d    = busy_q;
        err_d     = 1'b0;
        s_ready_d = s_ready_q;
        usr_rst_d = 1'b0;
        data_v_d  = 1'b0;
        in_data_d = in_data_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        done_d    = 1'b0;
        sent_clr  = 1'b0;
        sent_inc  = 1'b0;
        ret_clr   = 1'b0;
        ret_inc   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_len == '0) begin
                        err_d = 1'b1;
                    end else begin
                        len_d     = cfg_len;
                        busy_d    = 1'b1;
                        usr_rst_d = 1'b1;
                        state_d   = CLEAR;
                    end
                end
            end

            CLEAR: begin
                sent_clr  = 1'b1;
                ret_clr   = 1'b1;
                s_ready_d = 1'b1;  // len_q is never zero here
                state_d   = ACCUM;
            end

            ACCUM: begin
                ret_inc = heap_data_v_w;
                if (s_valid && s_ready_q) begin
                    in_data_d = s_data;
                    data_v_d  = 1'b1;
                    sent_inc  = 1'b1;
                    if (sent_last) begin
                        s_ready_d = 1'b0;
                        state_d   = DRAIN;
                    end
                end
            end

            DRAIN: begin
                if (heap_data_v_w) begin
                    ret_inc = 1'b1;
                    // Final return: take this cycle's heap registers.
                    if (ret_last) begin
                        m_data_d  = heap_data_w;
                        m_valid_d = 1'b1;
                        state_d   = OUT;
                    end
                end
            end

            OUT: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            s_ready_q <= 1'b0;
            usr_rst_q <= 1'b0;
            data_v_q  <= 1'b0;
            in_data_q <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            s_ready_q <= s_ready_d;
            usr_rst_q <= usr_rst_d;
            data_v_q  <= data_v_d;
            in_data_q <= in_data_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            done_q    <= done_d;
        end
    end

    assign busy         = busy_q;
    assign err_len0     = err_q;
    assign s_ready      = s_ready_q;
    assign heap_usr_rst = usr_rst_q;
    assign heap_data_v  = data_v_q;
    assign heap_in_data = in_data_q;
    assign m_valid      = m_valid_q;
    assign m_data       = m_data_q;
    assign done         = done_q;

endmodule

// File: doc/regheap_accum_ctrl.md
# regheap_accum_ctrl

Sequencer for the 64×16b self-adding register heap. Accepts one job: an accumulation length, then a stream of 1024-bit vectors over a valid/ready handshake. Clears the heap, feeds each vector to it as a single-cycle `data_v` beat, and counts the heap's returned valids. Captures the final 64-lane sum and holds it on a valid/ready output until it is taken. Sits between the feature-stream producer and the heap's consumer; the heap itself is instantiated alongside, not inside.

## Interface
Parameters:
- `DATA_W`, 1024, heap vector width (64 lanes × 16b)
- `CNT_W`, 8, job-length counter width; max job length 2^CNT_W−1

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; asynchronous, active-high
- `start`  in  1  job request, sampled only in IDLE
- `cfg_len`  in  CNT_W  vectors to accumulate, sampled with `start`
- `busy`  out  1  high in every state except IDLE
- `err_len0`  out  1  one-cycle pulse when `start` arrives with `cfg_len`==0
- `s_valid`  in  1  input vector valid
- `s_ready`  out  1  controller accepts input vector
- `s_data`  in  DATA_W  input vector
- `heap_usr_rst`  out  1  heap clear, one cycle
- `heap_data_v`  out  1  heap add strobe
- `heap_in_data`  out  DATA_W  heap add operand
- `heap_data_v_w`  in  1  heap output valid
- `heap_data_w`  in  DATA_W  heap output registers
- `m_valid`  out  1  result valid
- `m_ready`  in  1  result consumer ready
- `m_data`  out  DATA_W  captured result
- `done`  out  1  one-cycle pulse on result handshake

## Operation
- All outputs are registered. Reset value of every output is 0. Reset forces state IDLE and clears both counters.
- States are IDLE, CLEAR, ACCUM, DRAIN and OUT.
- IDLE:
  - `start` with `cfg_len`!=0 latches the length and goes to CLEAR.
  - `start` with `cfg_len`==0 pulses `err_len0` and stays in IDLE.
- CLEAR: lasts exactly one cycle, with `heap_usr_rst`=1. Clears `sent_cnt` and `ret_cnt`, then goes to ACCUM.
- ACCUM:
  - `s_ready`=1 while `sent_cnt` < len.
  - Each `s_valid&&s_ready` beat registers `s_data` into `heap_in_data`, asserts `heap_data_v` for one cycle, and increments `sent_cnt`.
  - When the last beat is accepted, `s_ready` drops in the same registered update and the state goes to DRAIN.
- `ret_cnt` increments on every `heap_data_v_w` from CLEAR exit onward, in ACCUM and in DRAIN.
- DRAIN:
  - When `heap_data_v_w` arrives and `ret_cnt`+1==len, `heap_data_w` is captured into `m_data` and the state goes to OUT.
  - The capture uses the heap value of that cycle, not a later one.
- OUT:
  - `m_valid`=1 and `m_data` is stable until `m_ready`.
  - On the handshake: `done` pulses, the state goes to IDLE, and `m_valid` drops.
- Arithmetic lives in the heap: per-lane 16b two's-complement add that wraps modulo 2^16. The controller never alters data.
- `heap_usr_rst` and `heap_data_v` are never high in the same cycle.
- `start` outside IDLE is ignored. `cfg_len` is not re-sampled.
- Input gaps (`s_valid` low) stall ACCUM indefinitely. There is no timeout.
- Reset mid-job aborts it. Any later beat or heap valid is ignored until the next CLEAR.

## Timing
- `start` at cycle t:
  - `busy` and `heap_usr_rst` are high at t+1.
  - `s_ready` is high at t+2.
- Beat accepted at cycle c: `heap_data_v` and `heap_in_data` are valid at c+1.
- The heap returns `heap_data_v_w` at c+2.
- Last beat at cycle c_L: `m_valid`=1 at c_L+3.
- Minimum job duration is len+4 cycles (with `m_ready` held high) plus one IDLE cycle.
- Throughput in ACCUM is one vector per cycle.
- `done` and `m_valid` fall are simultaneous, at the cycle after the handshake.
- The next `start` is accepted in the cycle `busy` is low.

## Structure
- Shared package `regheap_pkg` holds:
  - `LANES`=64, `LANE_W`=16, `DATA_W`=`LANES*LANE_W`
  - the state enum `rh_state_t` {IDLE, CLEAR, ACCUM, DRAIN, OUT}
- One sub-module is natural: `rh_beat_cnt`, a CNT_W up-counter with clear and terminal compare. It is instantiated twice, for the sent and returned counts.
- The FSM, the input register and the result register stay in the top.

## Test plan
- len=3, all lanes fed 1, 2, 3 back-to-back, `m_ready`=1 → `m_data` every lane 0x0006; `m_valid` at c_L+3; one `done`.
- len=2, lane0 fed 0xFFFF then 0x0002, others 0 → lane0 0x0001, others 0x0000.
- len=4 with `s_valid` gaps of 2 cycles and `m_ready` low for 5 cycles after `m_valid` → `m_data` stable throughout; `s_ready` never high in DRAIN or OUT.
- `start` with `cfg_len`=0 → `err_len0` one pulse; `busy` stays 0; no `heap_usr_rst`.
- Two back-to-back jobs with len=2 each (first sums 0x0010) → `heap_usr_rst` pulses before the second job; second result excludes first-job data.
- `rst` asserted after 1 of 3 beats → all outputs 0 asynchronously; new len=1 job with value 0x0007 → result 0x0007 per lane.
